// File: rtl/sr_bank_pkg.sv
// rtl/sr_bank_pkg.sv - op and FSM state encodings for the SR bank command arbiter
package sr_bank_pkg;
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_CLR = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_TGL = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;
endpackage

// File: rtl/sr_rr_arbiter.sv
// rtl/sr_rr_arbiter.sv - N-way round-robin arbiter with enable and one-hot grant
module sr_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] valid,
    output logic [N-1:0] grant
);
    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] nxt;
    logic [PW-1:0] idx;

    // Scan from the pointer, wrapping, and stop at the first valid requester.
    always_comb begin
        grant = '0;
        nxt   = ptr;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (en && grant == '0 && valid[idx]) begin
                grant[idx] = 1'b1;
                nxt        = PW'((int'(idx) + 1) % N);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= nxt;
        end
    end
endmodule

// File: rtl/sr_bank_cmd_arbiter.sv
// rtl/sr_bank_cmd_arbiter.sv - shares one SR cell bank between N command requesters
// Optional TOGGLE support (READ state) is built when SR_BANK_TOGGLE_EN is defined.
module sr_bank_cmd_arbiter
    import sr_bank_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = 16,
    parameter int AW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*2-1:0]  req_op,
    input  logic [W-1:0]    q_in,
    output logic [W-1:0]    s_out,
    output logic [W-1:0]    r_out,
    output logic            busy,
    output logic            err
);
    localparam logic [AW:0] W_LIM = (AW + 1)'(W);

    logic [1:0]    state;
    logic [N-1:0]  grant;
    logic          arb_en;
    logic          accept;
    logic [AW-1:0] g_addr;
    logic [1:0]    g_op;
    logic          g_ok;
    logic [W-1:0]  g_cell;

    // Reset also masks grants, so no requester sees ready while rst is low.
    assign arb_en    = rst && (state == ST_IDLE);
    assign req_ready = grant;
    assign accept    = |grant;
    assign busy      = (state != ST_IDLE);

    sr_rr_arbiter #(.N(N)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (arb_en),
        .valid (req_valid),
        .grant (grant)
    );

    always_comb begin
        g_addr = '0;
        g_op   = OP_NOP;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                g_addr = req_addr[i*AW +: AW];
                g_op   = req_op[i*2 +: 2];
            end
        end
    end

    assign g_ok   = {1'b0, g_addr} < W_LIM;
    assign g_cell = W'(1) << g_addr;

`ifdef SR_BANK_TOGGLE_EN
    logic [AW-1:0] cmd_addr;
    logic          c_ok;
    logic [W-1:0]  c_cell;

    assign c_ok   = {1'b0, cmd_addr} < W_LIM;
    assign c_cell = W'(1) << cmd_addr;
`else
    logic unused_q;
    assign unused_q = ^q_in;
`endif

    // Strobes and err are registered on entry to DRIVE and cleared every other cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            s_out <= '0;
            r_out <= '0;
            err   <= 1'b0;
`ifdef SR_BANK_TOGGLE_EN
            cmd_addr <= '0;
`endif
        end else begin
            s_out <= '0;
            r_out <= '0;
            err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_DRIVE;
                        case (g_op)
                            OP_SET: begin
                                if (g_ok) s_out <= g_cell;
                                else      err   <= 1'b1;
                            end
                            OP_CLR: begin
                                if (g_ok) r_out <= g_cell;
                                else      err   <= 1'b1;
                            end
                            OP_TGL: begin
`ifdef SR_BANK_TOGGLE_EN
                                state    <= ST_READ;
                                cmd_addr <= g_addr;
`else
                                err      <= 1'b1;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
`ifdef SR_BANK_TOGGLE_EN
                ST_READ: begin
                    state <= ST_DRIVE;
                    if (!c_ok)             err   <= 1'b1;
                    else if (q_in[cmd_addr]) r_out <= c_cell;
                    else                   s_out <= c_cell;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sr_bank_cmd_arbiter.sv
// tb/tb_sr_bank_cmd_arbiter.sv - self-checking bench for sr_bank_cmd_arbiter (N=4, W=12)
module tb_sr_bank_cmd_arbiter;
    localparam int N  = 4;
    localparam int W  = 12;
    localparam int AW = 4;
`ifdef SR_BANK_TOGGLE_EN
    localparam bit TGL_EN = 1'b1;
`else
    localparam bit TGL_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*2-1:0]  req_op;
    logic [W-1:0]    q_in;
    logic [W-1:0]    s_out;
    logic [W-1:0]    r_out;
    logic            busy;
    logic            err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    sr_bank_cmd_arbiter #(.N(N), .W(W), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_op    (req_op),
        .q_in      (q_in),
        .s_out     (s_out),
        .r_out     (r_out),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic set_cmd(input int r, input logic [1:0] op, input logic [AW-1:0] a);
        req_op[r*2 +: 2]    = op;
        req_addr[r*AW +: AW] = a;
    endtask

    // Model: schedule of expected strobes/err keyed by cycle, free = first cycle a grant may occur.
    logic [W-1:0] es[int];
    logic [W-1:0] erx[int];
    bit           ee[int];
    int           m_ptr    = 0;
    int           m_free   = 0;
    int           pend_cyc = -1;
    int           pend_a   = 0;
    int           g;
    int           a;
    logic [1:0]   op;
    logic [N-1:0] exp_rdy;

    always @(negedge clk) begin
        if (!rst) begin
            es.delete(); erx.delete(); ee.delete();
            m_ptr = 0; m_free = 0; pend_cyc = -1;
            chk("reset_outputs", {s_out, r_out, req_ready, busy, err}, 32'd0);
        end else begin
            chk("s_out", s_out, es.exists(cyc) ? es[cyc] : '0);
            chk("r_out", r_out, erx.exists(cyc) ? erx[cyc] : '0);
            chk("err", err, ee.exists(cyc) ? 1 : 0);
            chk("busy", busy, (cyc < m_free) ? 1 : 0);
            chk("s_r_exclusive", s_out & r_out, 32'd0);
            exp_rdy = '0;
            g = -1;
            if (cyc >= m_free) begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            if (g >= 0) begin
                op = req_op[g*2 +: 2];
                a  = int'(req_addr[g*AW +: AW]);
                m_ptr = (g + 1) % N;
                m_free = cyc + 2;
                case (op)
                    2'b10: if (a >= W) ee[cyc+1] = 1; else es[cyc+1] = W'(1) << a;
                    2'b01: if (a >= W) ee[cyc+1] = 1; else erx[cyc+1] = W'(1) << a;
                    2'b11: begin
                        if (TGL_EN) begin
                            m_free = cyc + 3; pend_cyc = cyc + 1; pend_a = a;
                        end else begin
                            ee[cyc+1] = 1;
                        end
                    end
                    default: ;
                endcase
            end
            if (pend_cyc == cyc) begin
                if (pend_a >= W)        ee[cyc+1]  = 1;
                else if (q_in[pend_a])  erx[cyc+1] = W'(1) << pend_a;
                else                    es[cyc+1]  = W'(1) << pend_a;
                pend_cyc = -1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '1;
        req_addr = '0;
        req_op = '0;
        q_in = '0;
        for (int i = 0; i < N; i++) set_cmd(i, 2'b10, AW'(i));
        #2 rst = 1'b0;

        // Reset held with every requester valid
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_reset_ready", req_ready, 32'd0);
        chk("t1_reset_s_out", s_out, 32'd0);
        step();
        rst = 1'b1;

        // Round-robin SETs to addr 0..3, requester 0 first after release
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_grant", req_ready, 32'(1 << (i % 4)));
            step();
            @(negedge clk);
            chk("t2_s_strobe", s_out, 32'(1 << (i % 4)));
            chk("t2_r_quiet", r_out, 32'd0);
            step();
        end
        req_valid = '0;
        step();

`ifdef SR_BANK_TOGGLE_EN
        q_in = 12'h020;
        set_cmd(1, 2'b11, 4'd5);
        req_valid = 4'b0010;
        @(negedge clk);
        chk("t3_grant", req_ready, 32'h2);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t3_read_busy", busy, 32'd1);
        step();
        @(negedge clk);
        chk("t3_r_strobe", r_out, 32'h020);
        step();
        q_in = 12'h000;
        set_cmd(2, 2'b11, 4'd5);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        @(negedge clk);
        chk("t3_s_strobe", s_out, 32'h020);
        step();
`else
        set_cmd(1, 2'b11, 4'd5);
        set_cmd(2, 2'b10, 4'd6);
        req_valid = 4'b0110;
        @(negedge clk);
        chk("t4_grant", req_ready, 32'h2);
        step();
        req_valid = 4'b0100;
        @(negedge clk);
        chk("t4_err", err, 32'd1);
        chk("t4_no_strobe", s_out | r_out, 32'd0);
        step();
        @(negedge clk);
        chk("t4_next_grant", req_ready, 32'h4);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t4_next_strobe", s_out, 32'h040);
        step();
`endif

        // Bad address from requester 3, then requester 0 served
        set_cmd(3, 2'b01, 4'd14);
        set_cmd(0, 2'b10, 4'd7);
        req_valid = 4'b1001;
        @(negedge clk);
        chk("t5_grant3", req_ready, 32'h8);
        step();
        req_valid = 4'b0001;
        @(negedge clk);
        chk("t5_err", err, 32'd1);
        chk("t5_no_strobe", s_out | r_out, 32'd0);
        step();
        @(negedge clk);
        chk("t5_grant0", req_ready, 32'h1);
        step();
        req_valid = '0;
        @(negedge clk);
        chk("t5_s_strobe", s_out, 32'h080);
        chk("t5_err_clear", err, 32'd0);
        step();

        // Async reset in the middle of a command
`ifdef SR_BANK_TOGGLE_EN
        q_in = 12'h020;
        set_cmd(1, 2'b11, 4'd5);
`else
        set_cmd(1, 2'b10, 4'd9);
`endif
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        #2 rst = 1'b0;
        #1;
        chk("t6_busy_cleared", busy, 32'd0);
        chk("t6_strobes_cleared", s_out | r_out, 32'd0);
        step();
        rst = 1'b1;
        repeat (4) step();
        @(negedge clk);
        chk("t6_no_replay", {s_out, r_out, busy}, 32'd0);
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
